// File: rtl/bmp_match_pkg.sv
// bmp_match_pkg: shared types and sizing helpers for the bitmap template matcher.
package bmp_match_pkg;

  // Default geometry: 64x24 pixel bitmaps, eight stored templates.
  localparam int DEF_COLS   = 64;
  localparam int DEF_ROWS   = 24;
  localparam int DEF_NTEMPL = 8;

  // Scoring run sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  // Template index width; at least one bit even for a single template.
  function automatic int idx_w(input int ntempl);
    return (ntempl > 1) ? $clog2(ntempl) : 1;
  endfunction

  // Row address width inside one template; at least one bit.
  function automatic int row_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Smallest score width that holds a perfect match of COLS*ROWS pixels.
  function automatic int min_score_w(input int cols, input int rows);
    return $clog2(cols * rows + 1);
  endfunction

endpackage

// File: rtl/bmp_popcount.sv
// bmp_popcount: combinational balanced adder tree counting the ones in a row.
module bmp_popcount #(
  parameter int COLS = 64,
  parameter int CW   = $clog2(COLS + 1)
) (
  input  logic [COLS-1:0] vec,
  output logic [CW-1:0]   count
);

  // Pad the row up to a power of two so every tree level halves cleanly.
  localparam int LV = (COLS > 1) ? $clog2(COLS) : 0;
  localparam int P  = 1 << LV;

  generate
    for (genvar gl = 0; gl <= LV; gl++) begin : g_lvl
      localparam int N = P >> gl;
      logic [CW-1:0] sum [N];
      for (genvar gi = 0; gi < N; gi++) begin : g_node
        if (gl == 0) begin : g_leaf
          if (gi < COLS) begin : g_bit
            assign sum[gi] = CW'(vec[gi]);
          end else begin : g_pad
            assign sum[gi] = '0;
          end
        end else begin : g_add
          assign sum[gi] = g_lvl[gl-1].sum[2*gi] + g_lvl[gl-1].sum[2*gi+1];
        end
      end
    end
  endgenerate

  assign count = g_lvl[LV].sum[0];

endmodule

// File: rtl/bmp_match_acc.sv
// bmp_match_acc: scores a latched image against NTEMPL stored template bitmaps,
// one row per cycle, and reports the best-matching template with a done pulse.
// Optional build macro BMP_MATCH_THRESH_EN adds a thresh input and match_valid
// output; an under-threshold best result reports best_idx as all-ones.
module bmp_match_acc
  import bmp_match_pkg::*;
#(
  parameter int COLS    = DEF_COLS,
  parameter int ROWS    = DEF_ROWS,
  parameter int NTEMPL  = DEF_NTEMPL,
  parameter int SCORE_W = 16,
  parameter int IDX_W   = idx_w(NTEMPL)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wren,
  input  logic [COLS*ROWS-1:0]          bitmap,
  input  logic                          tmpl_wren,
  input  logic [IDX_W+row_w(ROWS)-1:0]  tmpl_addr,
  input  logic [COLS-1:0]               tmpl_row,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [IDX_W-1:0]              best_idx,
  output logic [SCORE_W-1:0]            best_score
`ifdef BMP_MATCH_THRESH_EN
  ,
  input  logic [SCORE_W-1:0]            thresh,
  output logic                          match_valid
`endif
);

  localparam int RW    = row_w(ROWS);
  localparam int AW    = IDX_W + RW;
  localparam int PW    = $clog2(COLS + 1);
  localparam int DEPTH = 1 << AW;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   t_q, t_d, td_q, td_d, best_idx_q, best_idx_d;
  logic [RW-1:0]      r_q, r_d, rd_q, rd_d;
  logic               vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic [SCORE_W-1:0] acc_q, acc_d, best_score_q, best_score_d, final_score;
`ifdef BMP_MATCH_THRESH_EN
  logic               match_valid_q, match_valid_d;
`endif

  logic [COLS*ROWS-1:0] img_q;
  logic [COLS-1:0]      mem [DEPTH];
  logic [COLS-1:0]      mem_q;
  logic [AW-1:0]        rd_addr;
  logic [COLS-1:0]      img_row, xnor_row;
  logic [PW-1:0]        row_pc;
  logic                 store_open, last_addr;

  // Image and templates are only writable while no run is in flight.
  assign store_open = (state_q == S_IDLE) || (state_q == S_DONE);
  assign last_addr  = (t_q == IDX_W'(NTEMPL - 1)) && (r_q == RW'(ROWS - 1));
  assign rd_addr    = {t_q, r_q};

  // Image register; frozen during a run so every template sees the same image.
  always_ff @(posedge clk) begin
    if (wren && store_open) img_q <= bitmap;
  end

  // Template store: host write port plus one-cycle registered read for scoring.
  always_ff @(posedge clk) begin
    if (tmpl_wren && store_open) mem[tmpl_addr] <= tmpl_row;
    mem_q <= mem[rd_addr];
  end

  // The returning row pairs with the image row of the address issued last cycle.
  assign img_row     = img_q[rd_q*COLS +: COLS];
  assign xnor_row    = ~(img_row ^ mem_q);
  assign final_score = acc_q + SCORE_W'(row_pc);

  bmp_popcount #(.COLS(COLS), .CW(PW)) u_popcount (
    .vec   (xnor_row),
    .count (row_pc)
  );

  // Sequencer, address issue, accumulation and best-so-far tracking.
  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    r_d          = r_q;
    td_d         = td_q;
    rd_d         = rd_q;
    vld_d        = vld_q;
    acc_d        = acc_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
`ifdef BMP_MATCH_THRESH_EN
    match_valid_d = match_valid_q;
`endif

    if (vld_q && ((state_q == S_RUN) || (state_q == S_FLUSH))) begin
      if (rd_q == RW'(ROWS - 1)) begin
        acc_d = '0;
        // Template 0 always seeds the best; later ones must be strictly better.
        if ((td_q == '0) || (final_score > best_score_q)) begin
          best_score_d = final_score;
          best_idx_d   = td_q;
        end
      end else begin
        acc_d = final_score;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_FETCH;
          busy_d       = 1'b1;
          t_d          = '0;
          r_d          = '0;
          vld_d        = 1'b0;
          acc_d        = '0;
          best_idx_d   = '0;
          best_score_d = '0;
        end
      end
      S_FETCH, S_RUN: begin
        vld_d = 1'b1;
        td_d  = t_q;
        rd_d  = r_q;
        if (last_addr) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_RUN;
          if (r_q == RW'(ROWS - 1)) begin
            r_d = '0;
            t_d = t_q + 1'b1;
          end else begin
            r_d = r_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
`ifdef BMP_MATCH_THRESH_EN
        match_valid_d = (best_score_d >= thresh);
        if (!match_valid_d) best_idx_d = '1;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control and result registers, synchronously cleared while rst_n is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      r_q          <= '0;
      td_q         <= '0;
      rd_q         <= '0;
      vld_q        <= 1'b0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_idx_q   <= '0;
      best_score_q <= '0;
`ifdef BMP_MATCH_THRESH_EN
      match_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      r_q          <= r_d;
      td_q         <= td_d;
      rd_q         <= rd_d;
      vld_q        <= vld_d;
      acc_q        <= acc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
`ifdef BMP_MATCH_THRESH_EN
      match_valid_q <= match_valid_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign best_idx   = best_idx_q;
  assign best_score = best_score_q;
`ifdef BMP_MATCH_THRESH_EN
  assign match_valid = match_valid_q;
`endif

endmodule

// File: doc/bmp_match_acc.md
Name: bmp_match_acc

Overview:
- Parametrised successor to the bitmap compare accelerator.
- Holds one input bitmap of ROWS x COLS bits and NTEMPL stored template bitmaps.
- Scores the input against every template, one row per cycle. Score = count of matching pixels (popcount of XNOR).
- Reports the best-matching template index and its score to the music-recognition datapath, with a done pulse.

Parameters:
- COLS, 64, bits per bitmap row.
- ROWS, 24, rows per bitmap.
- NTEMPL, 8, number of stored templates.
- SCORE_W, 16, score/result width; must be >= clog2(COLS*ROWS+1).
- IDX_W, clog2(NTEMPL) (min 1), template index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- wren  in  1  latch bitmap into the image register.
- bitmap  in  COLS*ROWS  input image; row r = bits [r*COLS +: COLS].
- tmpl_wren  in  1  write one template row.
- tmpl_addr  in  IDX_W+clog2(ROWS)  {template index, row}.
- tmpl_row  in  COLS  template row data.
- start  in  1  begin a scoring run.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse; result valid.
- best_idx  out  IDX_W  winning template.
- best_score  out  SCORE_W  winning score.

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-low. On rst_n=0:
  - busy=0, done=0, best_idx=0, best_score=0.
  - FSM goes to IDLE; all counters and accumulators are cleared.
  - Image and template storage are not cleared.
- FSM states: IDLE, FETCH, RUN, FLUSH, DONE.
- IDLE:
  - wren=1 loads the image register.
  - tmpl_wren writes template memory in any state except RUN/FETCH/FLUSH; writes in those states are ignored.
  - start=1 goes to FETCH, sets busy=1, clears t, r, acc and best.
  - start and wren in the same cycle: the image loads first and the run uses the new image.
- FETCH: issue template memory read for (t=0, r=0). Memory is synchronous-read with 1-cycle latency. Go to RUN.
- RUN, each cycle:
  - acc += popcount(~(img_row[r_d] ^ mem_q)), where r_d is r delayed one cycle.
  - Issue the next address at the same time.
  - At last row of template t (r_d = ROWS-1), final = acc + row score:
    - If final > best_score, then best_score=final and best_idx=t.
    - Strictly greater only, so ties keep the lower index.
    - acc resets to 0.
  - After the last address is issued, go to FLUSH.
- FLUSH: consume the final read, do the final compare, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. best_idx/best_score hold until the next start or reset.
- Latency: with start sampled in cycle 0, done is high in cycle NTEMPL*ROWS+2. Default is 194.
- During a run (busy=1):
  - start is ignored.
  - wren is ignored, so the image is stable for the whole run.
- Before the first run completes, best_idx/best_score read 0. The first template is always accepted, since best starts at 0 and the minimum possible score compares as ">" only when nonzero.
- Rule for template 0 scoring exactly 0: template 0 is always taken as the initial best (idx 0), whatever its score.
- Score arithmetic: unsigned, SCORE_W wide, no saturation needed given the SCORE_W constraint. Maximum is COLS*ROWS = 1536.
- Reset mid-run: returns to IDLE within the reset cycle, no done pulse, outputs zeroed.

Optional Feature:
- Macro: BMP_MATCH_THRESH_EN.
- When defined:
  - Adds input port thresh [SCORE_W-1:0] and output match_valid [1].
  - match_valid is updated in the DONE cycle: 1 if best_score >= thresh, else 0.
  - When match_valid=0, best_idx is forced to all-ones and best_score still reports the true value.
  - match_valid resets to 0.
- When undefined: the ports are absent and behaviour is as above.

Decomposition:
- Package bmp_match_pkg holds:
  - the FSM state enum;
  - localparam helpers for IDX_W, row-address width and minimum SCORE_W;
  - default COLS/ROWS/NTEMPL.
- Sub-module bmp_popcount, parametrised by width COLS: combinational adder tree returning clog2(COLS+1) bits. Instantiated once in the RUN datapath.

Test Plan:
- Image = template 3 exactly; other templates are random -> done at cycle 194, best_idx=3, best_score=1536.
- Image all zeros; template 0 all ones, template 1 all zeros, the rest are checkerboard -> best_idx=1, best_score=1536.
- Templates 2 and 5 identical and best-matching (score 1500) -> best_idx=2, best_score=1500, tie resolved to the lower index.
- Start a run, then pulse wren with a new bitmap and a second start at cycle 50 -> result reflects the original image. One done at cycle 194; no second run.
- Assert rst_n=0 at cycle 100 of a run -> busy=0 and outputs 0 the next cycle, no done pulse. A fresh start afterwards completes normally in 194 cycles.
- With BMP_MATCH_THRESH_EN, thresh=1400:
  - best_score 1500 -> match_valid=1, best_idx correct.
  - best_score 1200 -> match_valid=0, best_idx=7 (all-ones), best_score=1200.
